gpr_file_sb: RTL and testbench
==============================

# gpr_file_sb

Parametrised general-purpose register file with an integrated write scoreboard, replacing the fixed 32x32 register file in the CPU core. It provides two combinational read ports and two write ports (EX/MEM writeback and load writeback), with same-cycle write-to-read forwarding. It also provides an optional hardwired-zero register 0. A per-register pending-write scoreboard lets the decode stage detect RAW hazards and stall until the producing write lands.

## Interface

**Parameters**
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register address width; depth = 2**ADDR_W.
- `ZERO_REG`, default 1: 1 = register 0 reads as 0 and ignores writes and issues; 0 = register 0 is ordinary.

**Ports**
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rd_addr_0`, `rd_addr_1`, in, ADDR_W: read addresses.
- `rd_data_0`, `rd_data_1`, out, DATA_W: read data; combinational, forwarded.
- `rd_busy_0`, `rd_busy_1`, out, 1: addressed register has a pending write that is not landing this cycle.
- `we_0`, in, 1: write enable, port 0.
- `wr_addr_0`, in, ADDR_W: write address, port 0.
- `wr_data_0`, in, DATA_W: write data, port 0.
- `we_1`, in, 1: write enable, port 1 (higher priority).
- `wr_addr_1`, in, ADDR_W: write address, port 1.
- `wr_data_1`, in, DATA_W: write data, port 1.
- `iss_en`, in, 1: an instruction that will write `iss_addr` is issued this cycle.
- `iss_addr`, in, ADDR_W: destination of the issued instruction.
- `flush`, in, 1: pipeline flush; clears all busy bits.
- `busy_cnt`, out, ADDR_W+1: registered count of set busy bits.

## Operation

**Storage and writes**
- Storage is an array of 2**ADDR_W words of DATA_W bits, plus a busy vector of 2**ADDR_W bits.
- Write: on the clock edge, `we_k` writes `wr_data_k` to `wr_addr_k`.
- Both ports writing the same address: port 1's data is stored.

**Reads**
- Read port n (combinational), evaluated in priority order:
  - `ZERO_REG`=1 and address 0 → 0.
  - Else `we_1` and `wr_addr_1` matches → `wr_data_1`.
  - Else `we_0` and `wr_addr_0` matches → `wr_data_0`.
  - Else the array content.

**Scoreboard**
- Per-register next state = (busy | set) & ~clear.
  - set = `iss_en` at `iss_addr`.
  - clear = any active write at that address.
- Issue and write to the same address in the same cycle: issue wins; the busy bit stays/becomes 1 because a newer producer is pending.
- `flush`=1: next busy = all zeros regardless of `iss_en` (flush wins). Writes in the same cycle still update data.
- Write to a non-busy register: data is updated, busy unchanged (stays 0). This is legal.
- `rd_busy_n` = busy[addr] & ~(matching active write this cycle). A same-cycle issue does not affect `rd_busy_n`.
- `ZERO_REG`=1 and address 0:
  - writes are ignored;
  - issues are ignored;
  - busy[0] is always 0, so `rd_busy` for address 0 is 0.

**busy_cnt**
- Registered popcount of the next busy vector, updated on the same edge as the busy vector.
- Always equals the number of set busy bits.

## Timing

**Reset**
- `rst`=1 at a clock edge clears every register, the busy vector and `busy_cnt` to 0.
- Reset overrides any write, issue or flush in that cycle.
- After reset: `rd_data_*` = 0 (absent forwarding), `rd_busy_*` = 0, `busy_cnt` = 0.
- Reset is honoured mid-operation with no residual pending state.

**Latencies**
- Read: 0 cycles (combinational from address and write inputs).
- Write visibility: same cycle via forwarding; from the array on the next cycle.
- Busy set: visible on `rd_busy` the cycle after `iss_en`.
- Busy clear: visible the same cycle as the write, via the bypass term.
- `busy_cnt`: reflects the state after the edge; lags events by one cycle.

**Timing constraints**
- No combinational path from `iss_en` or `flush` to any output.
- Combinational paths only from `rd_addr_*`, `we_*`, `wr_addr_*`, `wr_data_*` to `rd_data_*`/`rd_busy_*`.

## Test plan

- **Reset clear:** write 0xDEADBEEF to r5, issue r7, assert `rst` one cycle → r5 reads 0, `rd_busy` for r7 = 0, `busy_cnt` = 0.
- **Forwarding priority:** same cycle `we_0` r3=0x11, `we_1` r3=0x22, read r3 → `rd_data` = 0x22 that cycle and 0x22 next cycle.
- **Scoreboard basic:** issue r9 → next cycle `rd_busy` = 1, `busy_cnt` = 1; write r9=0x55 → `rd_busy` = 0 and `rd_data` = 0x55 that cycle; `busy_cnt` = 0 next cycle.
- **Issue/write collision:** r4 busy; same cycle write r4 and issue r4 → next cycle `rd_busy` = 1, `busy_cnt` = 1.
- **Flush:** busy r1, r2, r6; `flush` together with `iss_en` r8 → next cycle all `rd_busy` = 0, `busy_cnt` = 0.
- **Zero register (`ZERO_REG`=1):** write r0=0xFFFFFFFF and issue r0 → r0 reads 0 (including that same cycle), `rd_busy` = 0, `busy_cnt` unchanged. With `ZERO_REG`=0, r0 reads 0xFFFFFFFF.

Source files
------------

// File: rtl/gpr_file_sb.sv
// Register file with two read and two write ports, same-cycle write forwarding,
// an optional hardwired-zero r0 and a per-register pending-write scoreboard.
module gpr_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_0,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_busy_0,
  output logic              rd_busy_1,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [Depth-1:0]  r_busy;
  logic [Depth-1:0]  w_busy_d;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_d;
  logic              w_we_0;
  logic              w_we_1;
  logic              w_iss;

  // r0 writes and issues are dropped entirely when it is hardwired to zero.
  assign w_we_0 = we_0 & ~(ZERO_REG && (wr_addr_0 == '0));
  assign w_we_1 = we_1 & ~(ZERO_REG && (wr_addr_1 == '0));
  assign w_iss  = iss_en & ~(ZERO_REG && (iss_addr == '0));

  // Issue is applied after the clears so a new producer keeps the bit set.
  always_comb begin
    w_busy_d = r_busy;
    if (w_we_0) w_busy_d[wr_addr_0] = 1'b0;
    if (w_we_1) w_busy_d[wr_addr_1] = 1'b0;
    if (w_iss)  w_busy_d[iss_addr]  = 1'b1;
    if (flush)  w_busy_d = '0;
  end

  always_comb begin
    w_cnt_d = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      w_cnt_d = w_cnt_d + {{ADDR_W{1'b0}}, w_busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_we_0) r_mem[wr_addr_0] <= wr_data_0;
      if (w_we_1) r_mem[wr_addr_1] <= wr_data_1;
      r_busy <= w_busy_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign busy_cnt = r_cnt;

  logic [ADDR_W-1:0] w_ra [2];
  logic [DATA_W-1:0] w_rd [2];
  logic              w_rb [2];

  assign w_ra[0]   = rd_addr_0;
  assign w_ra[1]   = rd_addr_1;
  assign rd_data_0 = w_rd[0];
  assign rd_data_1 = w_rd[1];
  assign rd_busy_0 = w_rb[0];
  assign rd_busy_1 = w_rb[1];

  for (genvar n = 0; n < 2; n++) begin : g_rd
    logic w_hit_0;
    logic w_hit_1;

    assign w_hit_0 = w_we_0 && (wr_addr_0 == w_ra[n]);
    assign w_hit_1 = w_we_1 && (wr_addr_1 == w_ra[n]);

    always_comb begin
      if (ZERO_REG && (w_ra[n] == '0)) w_rd[n] = '0;
      else if (w_hit_1)                w_rd[n] = wr_data_1;
      else if (w_hit_0)                w_rd[n] = wr_data_0;
      else                             w_rd[n] = r_mem[w_ra[n]];
    end

    // A write landing this cycle retires the pending producer immediately.
    assign w_rb[n] = r_busy[w_ra[n]] & ~(w_hit_0 | w_hit_1);
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: directed scenarios plus random traffic against a
// register/scoreboard model, on a ZERO_REG=1 and a ZERO_REG=0 instance.
module tb_gpr_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] rd_addr_0, rd_addr_1, wr_addr_0, wr_addr_1, iss_addr;
  logic [DW-1:0] wr_data_0, wr_data_1;
  logic          we_0, we_1, iss_en, flush;

  logic [DW-1:0] a_rd_data_0, a_rd_data_1, b_rd_data_0, b_rd_data_1;
  logic          a_rd_busy_0, a_rd_busy_1, b_rd_busy_0, b_rd_busy_1;
  logic [AW:0]   a_busy_cnt, b_busy_cnt;

  gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_dut_z (
    .clk(clk), .rst(rst),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(a_rd_data_0), .rd_data_1(a_rd_data_1),
    .rd_busy_0(a_rd_busy_0), .rd_busy_1(a_rd_busy_1),
    .we_0(we_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .we_1(we_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(a_busy_cnt)
  );

  gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_dut_nz (
    .clk(clk), .rst(rst),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(b_rd_data_0), .rd_data_1(b_rd_data_1),
    .rd_busy_0(b_rd_busy_0), .rd_busy_1(b_rd_busy_1),
    .we_0(we_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .we_1(we_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(b_busy_cnt)
  );

  // Model state, index 0 = zero-register instance, 1 = ordinary r0.
  logic [DW-1:0] m_mem  [2][D];
  bit            m_busy [2][D];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_zero(input int inst, input logic [AW-1:0] a);
    return (inst == 0) && (a == '0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int inst, input logic [AW-1:0] a);
    if (is_zero(inst, a))             return '0;
    if (we_1 && wr_addr_1 == a)       return wr_data_1;
    if (we_0 && wr_addr_0 == a)       return wr_data_0;
    return m_mem[inst][a];
  endfunction

  function automatic logic exp_busy(input int inst, input logic [AW-1:0] a);
    if (is_zero(inst, a)) return 1'b0;
    return m_busy[inst][a] && !((we_1 && wr_addr_1 == a) || (we_0 && wr_addr_0 == a));
  endfunction

  function automatic int exp_cnt(input int inst);
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_busy[inst][i]);
    return c;
  endfunction

  task automatic check_outputs();
    check_eq("z_rd_data_0", a_rd_data_0, exp_rd(0, rd_addr_0));
    check_eq("z_rd_data_1", a_rd_data_1, exp_rd(0, rd_addr_1));
    check_eq("z_rd_busy_0", a_rd_busy_0, exp_busy(0, rd_addr_0));
    check_eq("z_rd_busy_1", a_rd_busy_1, exp_busy(0, rd_addr_1));
    check_eq("z_busy_cnt",  a_busy_cnt,  exp_cnt(0));
    check_eq("nz_rd_data_0", b_rd_data_0, exp_rd(1, rd_addr_0));
    check_eq("nz_rd_data_1", b_rd_data_1, exp_rd(1, rd_addr_1));
    check_eq("nz_rd_busy_0", b_rd_busy_0, exp_busy(1, rd_addr_0));
    check_eq("nz_rd_busy_1", b_rd_busy_1, exp_busy(1, rd_addr_1));
    check_eq("nz_busy_cnt",  b_busy_cnt,  exp_cnt(1));
  endtask

  task automatic model_update();
    for (int inst = 0; inst < 2; inst++) begin
      if (rst) begin
        for (int i = 0; i < D; i++) begin
          m_mem[inst][i]  = '0;
          m_busy[inst][i] = 1'b0;
        end
      end else begin
        if (we_0 && !is_zero(inst, wr_addr_0)) begin
          m_mem[inst][wr_addr_0]  = wr_data_0;
          m_busy[inst][wr_addr_0] = 1'b0;
        end
        if (we_1 && !is_zero(inst, wr_addr_1)) begin
          m_mem[inst][wr_addr_1]  = wr_data_1;
          m_busy[inst][wr_addr_1] = 1'b0;
        end
        if (iss_en && !is_zero(inst, iss_addr)) m_busy[inst][iss_addr] = 1'b1;
        if (flush) for (int i = 0; i < D; i++) m_busy[inst][i] = 1'b0;
      end
    end
  endtask

  // Inputs are applied at posedge+1; outputs are sampled at posedge+4 or later.
  task automatic step(input bit chk);
    #3;
    if (chk) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we_0 = 1'b0; we_1 = 1'b0; iss_en = 1'b0; flush = 1'b0;
    wr_addr_0 = '0; wr_addr_1 = '0; wr_data_0 = '0; wr_data_1 = '0; iss_addr = '0;
  endtask

  initial begin
    idle();
    rd_addr_0 = '0;
    rd_addr_1 = '0;
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    step(1'b1);
    rst = 1'b0;

    // Reset clear
    we_0 = 1'b1; wr_addr_0 = 5'd5; wr_data_0 = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd7;
    step(1'b1);
    idle(); rst = 1'b1;
    step(1'b1);
    idle(); rd_addr_0 = 5'd5; rd_addr_1 = 5'd7;
    #3;
    check_eq("rst_r5", a_rd_data_0, 32'h0);
    check_eq("rst_busy_r7", a_rd_busy_1, 1'b0);
    check_eq("rst_cnt", a_busy_cnt, 6'd0);
    step(1'b1);

    // Forwarding priority
    we_0 = 1'b1; wr_addr_0 = 5'd3; wr_data_0 = 32'h11;
    we_1 = 1'b1; wr_addr_1 = 5'd3; wr_data_1 = 32'h22;
    rd_addr_0 = 5'd3;
    #3;
    check_eq("fwd_pri", a_rd_data_0, 32'h22);
    step(1'b1);
    idle();
    #3;
    check_eq("fwd_pri_next", a_rd_data_0, 32'h22);
    step(1'b1);

    // Scoreboard basic
    iss_en = 1'b1; iss_addr = 5'd9; rd_addr_0 = 5'd9;
    step(1'b1);
    idle();
    #3;
    check_eq("sb_busy", a_rd_busy_0, 1'b1);
    check_eq("sb_cnt", a_busy_cnt, 6'd1);
    step(1'b1);
    we_0 = 1'b1; wr_addr_0 = 5'd9; wr_data_0 = 32'h55;
    #3;
    check_eq("sb_clr_busy", a_rd_busy_0, 1'b0);
    check_eq("sb_clr_data", a_rd_data_0, 32'h55);
    step(1'b1);
    idle();
    #3;
    check_eq("sb_clr_cnt", a_busy_cnt, 6'd0);
    step(1'b1);

    // Issue/write collision
    iss_en = 1'b1; iss_addr = 5'd4; rd_addr_0 = 5'd4;
    step(1'b1);
    we_1 = 1'b1; wr_addr_1 = 5'd4; wr_data_1 = 32'h44; iss_en = 1'b1; iss_addr = 5'd4;
    step(1'b1);
    idle();
    #3;
    check_eq("coll_busy", a_rd_busy_0, 1'b1);
    check_eq("coll_cnt", a_busy_cnt, 6'd1);
    step(1'b1);

    // Flush (r4 is still busy from above)
    foreach (m_busy[0][i]) begin end
    iss_en = 1'b1; iss_addr = 5'd1; step(1'b1);
    iss_en = 1'b1; iss_addr = 5'd2; step(1'b1);
    iss_en = 1'b1; iss_addr = 5'd6; step(1'b1);
    idle();
    #3;
    check_eq("pre_flush_cnt", a_busy_cnt, 6'd4);
    step(1'b1);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd8;
    step(1'b1);
    idle(); rd_addr_0 = 5'd8; rd_addr_1 = 5'd6;
    #3;
    check_eq("flush_busy_r8", a_rd_busy_0, 1'b0);
    check_eq("flush_busy_r6", a_rd_busy_1, 1'b0);
    check_eq("flush_cnt", a_busy_cnt, 6'd0);
    step(1'b1);

    // Zero register
    we_0 = 1'b1; wr_addr_0 = 5'd0; wr_data_0 = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr_0 = 5'd0; rd_addr_1 = 5'd0;
    #3;
    check_eq("zero_same_cycle", a_rd_data_0, 32'h0);
    step(1'b1);
    idle();
    #3;
    check_eq("zero_rd", a_rd_data_0, 32'h0);
    check_eq("zero_busy", a_rd_busy_0, 1'b0);
    check_eq("zero_cnt", a_busy_cnt, 6'd0);
    check_eq("nonzero_r0", b_rd_data_0, 32'hFFFFFFFF);
    check_eq("nonzero_r0_busy", b_rd_busy_0, 1'b1);
    step(1'b1);

    // Random traffic on a narrow address range to force collisions
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      we_0      = $urandom_range(0, 1);
      we_1      = ($urandom_range(0, 2) == 0);
      iss_en    = ($urandom_range(0, 4) < 2);
      wr_addr_0 = AW'($urandom_range(0, 7));
      wr_addr_1 = AW'($urandom_range(0, 7));
      iss_addr  = AW'($urandom_range(0, 7));
      rd_addr_0 = AW'($urandom_range(0, 7));
      rd_addr_1 = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_data_0 = $urandom;
      wr_data_1 = $urandom;
      step(1'b1);
    end
    idle();
    step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
